// File: rtl/result_checker.sv
// result_checker
// ---------------------------------------------------------------------------
// Monitors the CPU data-memory write bus during a self-checking test program.
// NUM_PORTS consecutive word addresses starting at BASE_ADDR are "result
// ports". The first write to each port is compared against a run-time
// loadable expected-value table. Mismatches are counted, the time spent
// checking is measured, and finish rises once every port has been written
// or the optional timeout expires. On a timeout, every port that was never
// written is charged as one error.
//
// Ports:
//   clk          clock
//   rst          asynchronous reset, active low
//   addr         write word address
//   data         write data, in bus byte order
//   wen          write enable; may stay high for several cycles while stalled
//   exp_load     load one expected-table entry (accepted in IDLE only)
//   exp_idx      table index for exp_load
//   exp_data     expected value for exp_load, already in readable byte order
//   error_num    mismatch count (all ones until the first checked write)
//   duration     cycles spent in CHECK, saturating
//   finish       high once the run is reported
//   pass         finish with zero errors
//   timed_out    the report was caused by the timeout
//   checked_mask bit i set once port i has been checked
// ---------------------------------------------------------------------------
module result_checker #(
  parameter int                NUM_PORTS = 14,
  parameter int                ADDR_W    = 30,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  parameter int                DATA_W    = 32,
  parameter bit                BYTE_SWAP = 1'b1,
  parameter int                ERR_W     = 8,
  parameter int                DUR_W     = 16,
  parameter int unsigned       TIMEOUT   = 32'hFFFF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [ADDR_W-1:0]    addr,
  input  logic [DATA_W-1:0]    data,
  input  logic                 wen,
  input  logic                 exp_load,
  input  logic [5:0]           exp_idx,
  input  logic [DATA_W-1:0]    exp_data,
  output logic [ERR_W-1:0]     error_num,
  output logic [DUR_W-1:0]     duration,
  output logic                 finish,
  output logic                 pass,
  output logic                 timed_out,
  output logic [NUM_PORTS-1:0] checked_mask
);

  localparam int IDX_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int NB    = DATA_W / 8;
  // Wide enough to hold the number of unchecked ports (0..64).
  localparam int CNT_W = 7;
  localparam int SUM_W = ERR_W + CNT_W;

  localparam logic [ADDR_W-1:0] NP_ADDR     = ADDR_W'(NUM_PORTS);
  localparam logic [6:0]        NP_IDX      = 7'(NUM_PORTS);
  localparam bit                TIMEOUT_EN  = (TIMEOUT != 0);
  localparam logic [DUR_W-1:0]  TIMEOUT_END = DUR_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CHECK  = 2'd1,
    REPORT = 2'd2
  } state_t;

  state_t state;
  logic   wen_hist;

  logic [DATA_W-1:0] exp_table [NUM_PORTS];

  logic                 wr_event;
  logic [ADDR_W-1:0]    offset;
  logic                 in_window;
  logic [IDX_W-1:0]     idx;
  logic                 hit;
  logic [DATA_W-1:0]    cmp_data;
  logic                 mismatch;
  logic [NUM_PORTS-1:0] onehot;
  logic                 new_port;
  logic [NUM_PORTS-1:0] mask_upd;
  logic                 all_done;
  logic [ERR_W-1:0]     err_upd;
  logic [CNT_W-1:0]     unchecked;
  logic [SUM_W-1:0]     err_sum;
  logic [ERR_W-1:0]     err_penalty;
  logic                 timeout_hit;
  logic                 load_ok;

  // A held wen (bus stall) must produce only one event, so detect its rising edge.
  assign wr_event = wen & ~wen_hist;

  // Checking addr >= BASE_ADDR first keeps the subtraction from wrapping,
  // and avoids computing BASE_ADDR + NUM_PORTS, which could overflow.
  assign offset    = addr - BASE_ADDR;
  assign in_window = (addr >= BASE_ADDR) && (offset < NP_ADDR);
  assign idx       = offset[IDX_W-1:0];
  assign hit       = wr_event & in_window;

  genvar gi;
  generate
    if (BYTE_SWAP) begin : g_swap
      for (gi = 0; gi < NB; gi++) begin : g_byte
        assign cmp_data[8*gi +: 8] = data[8*(NB-1-gi) +: 8];
      end
    end else begin : g_raw
      assign cmp_data = data;
    end

    for (gi = 0; gi < NUM_PORTS; gi++) begin : g_onehot
      assign onehot[gi] = (idx == IDX_W'(gi));
    end
  endgenerate

  assign mismatch = cmp_data != exp_table[idx];
  assign new_port = hit && ((checked_mask & onehot) == '0);
  assign mask_upd = checked_mask | (new_port ? onehot : '0);
  assign all_done = &mask_upd;
  assign err_upd  = (new_port && mismatch && (error_num != '1)) ? error_num + 1'b1 : error_num;

  always_comb begin
    unchecked = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      unchecked = unchecked + {{(CNT_W-1){1'b0}}, ~mask_upd[i]};
    end
  end

  // Timeout penalty: one error for every port still unchecked, saturating.
  assign err_sum     = {{CNT_W{1'b0}}, err_upd} + {{ERR_W{1'b0}}, unchecked};
  assign err_penalty = (|err_sum[SUM_W-1:ERR_W]) ? '1 : err_sum[ERR_W-1:0];

  assign timeout_hit = TIMEOUT_EN && (duration == TIMEOUT_END);
  assign load_ok     = exp_load && ({1'b0, exp_idx} < NP_IDX);

  assign pass = finish && (error_num == '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      wen_hist     <= 1'b0;
      error_num    <= '1;
      duration     <= '0;
      finish       <= 1'b0;
      timed_out    <= 1'b0;
      checked_mask <= '0;
      for (int i = 0; i < NUM_PORTS; i++) begin
        exp_table[i] <= '0;
      end
    end else begin
      wen_hist <= wen;
      case (state)
        IDLE: begin
          if (load_ok) begin
            exp_table[exp_idx[IDX_W-1:0]] <= exp_data;
          end
          if (hit) begin
            state        <= CHECK;
            error_num    <= mismatch ? ERR_W'(1) : '0;
            checked_mask <= onehot;
          end
        end
        CHECK: begin
          if (duration != '1) begin
            duration <= duration + 1'b1;
          end
          checked_mask <= mask_upd;
          // Completion takes priority over a timeout in the same cycle.
          if (all_done) begin
            state     <= REPORT;
            finish    <= 1'b1;
            error_num <= err_upd;
          end else if (timeout_hit) begin
            state     <= REPORT;
            finish    <= 1'b1;
            timed_out <= 1'b1;
            error_num <= err_penalty;
          end else begin
            error_num <= err_upd;
          end
        end
        REPORT: begin
          // Terminal: everything stays frozen until reset.
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
